// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port core memory between instruction
// fetch (IF) and load/store (D). Each requester uses a req/ack handshake;
// the block latches the winner's operands, waits RD_LATENCY cycles for read
// data, then returns it with a one-cycle ack. Misaligned D accesses are
// answered with d_err and never reach memory.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (default build uses fixed D-over-IF priority).
module mem_port_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [1:0]  SZ_BYTE    = 2'b00,
  parameter logic [1:0]  SZ_HALF    = 2'b01,
  parameter logic [1:0]  SZ_WORD    = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sz_ex,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_in_data,
  output logic [1:0]  mem_size,
  output logic        mem_sz_ex,
  input  logic [31:0] mem_out_data,
  output logic        busy
);

  localparam int unsigned     CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              gnt_d, gnt_d_n;
  logic              err, err_n;
  logic              store, store_n;

  logic              if_ack_n, d_ack_n, d_err_n, busy_n;
  logic [31:0]       if_rdata_n, d_rdata_n;
  logic              wr_en_n, sz_ex_n;
  logic [31:0]       address_n, in_data_n;
  logic [1:0]        size_n;

  logic              misaligned_c;
  logic              pick_d_c;

  // Alignment check of the current D request; bytes are always aligned
  always_comb begin
    misaligned_c = 1'b0;
    if (d_size == SZ_WORD)      misaligned_c = (d_addr[1:0] != 2'b00);
    else if (d_size == SZ_HALF) misaligned_c = d_addr[0];
    else if (d_size == SZ_BYTE) misaligned_c = 1'b0;
  end

`ifdef MEM_ARB_RR_EN
  logic last_d, last_d_n;
  // Most recently granted requester loses a tie
  assign pick_d_c = d_req && (!if_req || !last_d);
`else
  // D always beats IF
  assign pick_d_c = d_req;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gnt_d_n    = gnt_d;
    err_n      = err;
    store_n    = store;
    if_ack_n   = 1'b0;
    d_ack_n    = 1'b0;
    d_err_n    = 1'b0;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    wr_en_n    = 1'b0;
    address_n  = mem_address;
    in_data_n  = mem_in_data;
    size_n     = mem_size;
    sz_ex_n    = mem_sz_ex;
`ifdef MEM_ARB_RR_EN
    last_d_n   = last_d;
`endif

    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (d_req || if_req) last_d_n = pick_d_c;
`endif
        if (pick_d_c) begin
          gnt_d_n = 1'b1;
          if (misaligned_c) begin
            err_n     = 1'b1;
            store_n   = 1'b0;
            d_rdata_n = 32'd0;
            state_n   = DONE;
          end else begin
            err_n     = 1'b0;
            store_n   = d_we;
            wr_en_n   = d_we;
            address_n = d_addr;
            in_data_n = d_wdata;
            size_n    = d_size;
            sz_ex_n   = d_sz_ex;
            cnt_n     = CNT_LOAD;
            state_n   = ACCESS;
          end
        end else if (if_req) begin
          gnt_d_n   = 1'b0;
          err_n     = 1'b0;
          store_n   = 1'b0;
          address_n = if_addr;
          in_data_n = 32'd0;
          size_n    = SZ_WORD;
          sz_ex_n   = 1'b0;
          cnt_n     = CNT_LOAD;
          state_n   = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt == '0) begin
          if (gnt_d) d_rdata_n  = store ? 32'd0 : mem_out_data;
          else       if_rdata_n = mem_out_data;
          address_n = 32'd0;
          in_data_n = 32'd0;
          size_n    = SZ_WORD;
          sz_ex_n   = 1'b0;
          state_n   = DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      DONE: begin
        if_ack_n = !gnt_d;
        d_ack_n  = gnt_d;
        d_err_n  = gnt_d && err;
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_d       <= 1'b0;
      err         <= 1'b0;
      store       <= 1'b0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      if_rdata    <= 32'd0;
      d_rdata     <= 32'd0;
      mem_wr_en   <= 1'b0;
      mem_address <= 32'd0;
      mem_in_data <= 32'd0;
      mem_size    <= SZ_WORD;
      mem_sz_ex   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gnt_d       <= gnt_d_n;
      err         <= err_n;
      store       <= store_n;
      if_ack      <= if_ack_n;
      d_ack       <= d_ack_n;
      d_err       <= d_err_n;
      if_rdata    <= if_rdata_n;
      d_rdata     <= d_rdata_n;
      mem_wr_en   <= wr_en_n;
      mem_address <= address_n;
      mem_in_data <= in_data_n;
      mem_size    <= size_n;
      mem_sz_ex   <= sz_ex_n;
      busy        <= busy_n;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-grant register; after reset IF counts as most recent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d <= 1'b0;
    else     last_d <= last_d_n;
  end
`endif

endmodule
